instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the riscv-small pipeline; feeds instruction decode via the IF/ID register.
//  Holds the PC and fetches one word at a time from instruction memory (req/gnt/rvalid).
//  Takes redirects from decode (branch_taken/jump_addr) and stalls from the hazard logic.
//  Discards fetches made stale by a redirect and issues a NOP bubble.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC value after reset
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous reset, active low
//  clk_en       in   1   clock enable; low freezes all state
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address; stable while imem_req && !imem_gnt
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   imem_rdata valid (at least 1 cycle after gnt)
//  imem_rdata   in   32  fetched instruction word
//  branch_taken in   1   redirect from decode
//  jump_addr    in   32  redirect target
//  stall        in   1   hold IF/ID contents (load-use hazard)
//  inst         out  32  IF/ID instruction (instruction_u)
//  pc           out  32  IF/ID PC of inst
//  inst_valid   out  1   inst is a real fetched instruction
// BEHAVIOUR
//  Interface: one clock (clk); reset asynchronous, active-low (rst_n); polarity/sync fixed.
//  Reset: state=REQ, fetch_pc=RESET_ADDR, inst=NOP_INST (32'h0000_0013), pc=0,
//    inst_valid=0, skid empty, kill=0. imem_req rises in the first cycle after reset.
//  Sequencing:
//    - All updates are gated by clk_en.
//    - One request outstanding max. imem_req=(state==REQ) && !skid_full. imem_addr=fetch_pc.
//  FSM states:
//    - REQ: on gnt -> WAIT; fetch_pc += 4.
//    - WAIT: on rvalid -> REQ. The word goes to IF/ID if !stall, else to the skid buffer.
//      If kill is set, the word is dropped and kill clears.
//    - rvalid outside WAIT is ignored.
//  Zero-wait memory: throughput is 1 instruction per 2 cycles; gnt-to-inst latency is 2 cycles.
//  Redirect (branch_taken=1, has priority over stall):
//    - inst_valid<=0 and inst<=NOP_INST next cycle; skid buffer flushed.
//    - REQ ungranted: imem_addr must hold. Set kill; keep target in redirect_pc. On gnt,
//      fetch_pc<=redirect_pc and go to WAIT with kill=1.
//    - REQ granted this same cycle: fetch_pc<=jump_addr, WAIT with kill=1.
//    - WAIT: kill=1; fetch_pc<=jump_addr. Also applies if rvalid arrives in the same cycle
//      (that word is dropped).
//  Stall:
//    - inst/pc/inst_valid hold.
//    - A response arriving during stall fills the skid buffer. imem_req stays low while it is full.
//    - When stall falls, the skid entry loads IF/ID in that cycle; REQ resumes the next cycle.
//  Wrap: fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
//  Reset mid-operation: everything returns to reset values immediately; in-flight response ignored.
// CONFIGURATION
//  IF_MISALIGN_CHK_EN defined:
//    - Adds output if_misalign (1 bit, reset 0).
//    - On a redirect with jump_addr[1:0]!=0: if_misalign=1; no fetch is issued and
//      inst_valid stays 0 until the next redirect or reset.
//    - Other redirect side effects (kill, flush) are unchanged.
//  Undefined: no port; jump_addr[1:0] forced to 2'b00.
// STRUCTURE
//  riscv_definitions gets:
//    - fetch_state_e {REQ, WAIT}
//    - localparam NOP_INST = 32'h0000_0013
//    - reuses instruction_u
//  Sub-module fetch_skid_buf: 1-entry {inst,pc} buffer with full flag, flush, and clk_en.
// TESTING
//  - Reset, zero-wait memory, rdata=addr: inst_valid every 2nd cycle; pc 0,4,8,C; wrap check
//    with RESET_ADDR=32'hFFFF_FFF8.
//  - gnt delayed 3 cycles: imem_addr stable; exactly one request per address; no duplicate inst.
//  - branch_taken in WAIT to 32'h100, then rvalid: stale word dropped; next valid inst
//    has pc=32'h100.
//  - branch_taken in ungranted REQ, gnt 2 cycles later: that fetch killed; next imem_addr=target.
//  - stall=1 for 4 cycles across an rvalid: IF/ID held; imem_req low; word appears the cycle
//    stall falls; no loss or duplication.
//  - IF_MISALIGN_CHK_EN, jump_addr=32'h102: if_misalign=1, imem_req=0 until a redirect to 32'h200.

Source files
------------

// File: rtl/riscv_definitions.sv
// Shared riscv-small types used by the fetch stage: instruction word union,
// fetch FSM states and the canonical NOP encoding (addi x0, x0, 0).
package riscv_definitions;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef union packed {
        logic [31:0] raw;
        r_type_t     r;
    } instruction_u;

    typedef struct packed {
        instruction_u inst;
        logic [31:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding register for a response that lands while IF/ID is stalled.
module fetch_skid_buf
    import riscv_definitions::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clk_en) begin
            if (flush) begin
                full <= 1'b0;
            end else if (push) begin
                full <= 1'b1;
                dout <= din;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, single-outstanding imem fetch, redirect kill and stall skid.
// Optional IF_MISALIGN_CHK_EN adds if_misalign and blocks fetch on misaligned targets.
module instruction_fetch
    import riscv_definitions::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    input  logic         branch_taken,
    input  logic [31:0]  jump_addr,
    input  logic         stall,
    output instruction_u inst,
    output logic [31:0]  pc,
`ifdef IF_MISALIGN_CHK_EN
    output logic         if_misalign,
`endif
    output logic         inst_valid
);

    fetch_state_e state, state_d;
    logic [31:0]  fetch_pc, redirect_pc, jmp, rsp_pc;
    logic         kill, misalign, gnt_acc, rsp, skid_full;
    fetch_entry_t skid_din, skid_q;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      misalign_q <= 1'b0;
        else if (clk_en && branch_taken) misalign_q <= |jump_addr[1:0];
    end
    assign misalign    = misalign_q;
    assign if_misalign = misalign_q;
    assign jmp         = jump_addr;
`else
    logic unused_jump_lsb;
    assign unused_jump_lsb = ^jump_addr[1:0];
    assign misalign        = 1'b0;
    assign jmp             = {jump_addr[31:2], 2'b00};
`endif

    assign gnt_acc  = imem_req && imem_gnt;
    assign rsp      = (state == WAIT) && imem_rvalid;
    // In WAIT fetch_pc already points past the outstanding word
    assign rsp_pc   = fetch_pc - 32'd4;
    assign skid_din = {imem_rdata, rsp_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state <= REQ;
        else if (clk_en) state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            REQ:     if (gnt_acc) state_d = WAIT;
            WAIT:    if (imem_rvalid) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem_req  = (state == REQ) && !skid_full && !misalign;
        imem_addr = fetch_pc;
    end

    // kill marks the outstanding (or about-to-be-granted) fetch as stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_ADDR;
            redirect_pc <= RESET_ADDR;
            kill        <= 1'b0;
        end else if (clk_en) begin
            case (state)
                REQ: begin
                    if (gnt_acc) begin
                        kill     <= kill | branch_taken;
                        fetch_pc <= branch_taken ? jmp : (kill ? redirect_pc : fetch_pc + 32'd4);
                    end else if (branch_taken) begin
                        if (imem_req) begin
                            kill        <= 1'b1;
                            redirect_pc <= jmp;
                        end else begin
                            kill     <= 1'b0;
                            fetch_pc <= jmp;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (branch_taken) fetch_pc <= jmp;
                    end else if (branch_taken) begin
                        kill     <= 1'b1;
                        fetch_pc <= jmp;
                    end
                end
                default: kill <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= NOP_INST;
            pc         <= 32'h0;
            inst_valid <= 1'b0;
        end else if (clk_en) begin
            if (branch_taken) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end else if (!stall) begin
                if (skid_full) begin
                    inst       <= skid_q.inst;
                    pc         <= skid_q.pc;
                    inst_valid <= 1'b1;
                end else if (rsp && !kill) begin
                    inst       <= imem_rdata;
                    pc         <= rsp_pc;
                    inst_valid <= 1'b1;
                end else begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                end
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .push   (rsp && !kill && stall && !branch_taken),
        .pop    (!stall && skid_full && !branch_taken),
        .flush  (branch_taken),
        .din    (skid_din),
        .dout   (skid_q),
        .full   (skid_full)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns rdata = address.
module tb_instruction_fetch;
    import riscv_definitions::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, clk_en = 1'b1, branch_taken = 1'b0, stall = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid, inst_valid;
    logic [31:0] imem_addr, imem_rdata, jump_addr = 32'h0, inst, pc;
    logic        req2, rv2, v2;
    logic [31:0] addr2, rd2, inst2, pc2;
`ifdef IF_MISALIGN_CHK_EN
    logic        if_misalign, misalign2;
`endif

    int checks = 0, errors = 0;
    int gnt_delay = 0, rsp_lat = 0, req_age, pend_cnt;
    logic        pend;
    logic [31:0] pend_addr;

    // memory model: grant after gnt_delay cycles of request, respond rsp_lat cycles after accept
    assign imem_gnt    = imem_req && (req_age >= gnt_delay);
    assign imem_rvalid = pend && (pend_cnt == 0);
    assign imem_rdata  = pend_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_age <= 0; pend <= 1'b0; pend_cnt <= 0; pend_addr <= 32'h0;
        end else if (clk_en) begin
            req_age <= (imem_req && !imem_gnt) ? req_age + 1 : 0;
            if (imem_req && imem_gnt) begin
                pend <= 1'b1; pend_addr <= imem_addr; pend_cnt <= rsp_lat;
            end else if (pend) begin
                if (pend_cnt == 0) pend <= 1'b0;
                else pend_cnt <= pend_cnt - 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin rv2 <= 1'b0; rd2 <= 32'h0; end
        else begin rv2 <= req2; rd2 <= addr2; end
    end

    instruction_fetch #(.RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .jump_addr(jump_addr), .stall(stall), .inst(inst), .pc(pc),
`ifdef IF_MISALIGN_CHK_EN
        .if_misalign(if_misalign),
`endif
        .inst_valid(inst_valid));

    instruction_fetch #(.RESET_ADDR(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(req2), .imem_rvalid(rv2), .imem_rdata(rd2),
        .branch_taken(1'b0), .jump_addr(32'h0), .stall(1'b0), .inst(inst2), .pc(pc2),
`ifdef IF_MISALIGN_CHK_EN
        .if_misalign(misalign2),
`endif
        .inst_valid(v2));

    // Leaves the caller at the negedge where reset is released (cycle k=0).
    task automatic do_reset();
        rst_n = 1'b0; clk_en = 1'b1; branch_taken = 1'b0; jump_addr = 32'h0; stall = 1'b0;
        gnt_delay = 0; rsp_lat = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst !== NOP_INST) begin errors++; $display("FAIL rst_inst got %h exp %h", inst, NOP_INST); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_req got %b/%h exp 1/0", imem_req, imem_addr); end
        for (int k = 1; k <= 5; k++) @(negedge clk);
        // k=5: word for pc 4 in IF/ID, fetch of 8 in flight
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || inst_valid !== 1'b0 || inst !== NOP_INST) begin errors++; $display("FAIL rst_mid got pc %h v %b inst %h exp 0/0/%h", pc, inst_valid, inst, NOP_INST); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got %h exp 0", imem_addr); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight got %b exp 0", inst_valid); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL rst_restart got %b/%h exp 1/0", inst_valid, pc); end
    endtask

    task automatic test_zero_wait();
        logic        ev;
        logic [31:0] ep;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ev = (k % 2 == 0);
            checks++; if (inst_valid !== ev || v2 !== ev) begin errors++; $display("FAIL zw_valid k=%0d got %b/%b exp %b", k, inst_valid, v2, ev); end
            if (ev) begin
                ep = (k / 2 - 1) * 4;
                checks++; if (pc !== ep || inst !== ep) begin errors++; $display("FAIL zw_pc k=%0d got %h/%h exp %h", k, pc, inst, ep); end
                checks++; if (pc2 !== 32'hFFFF_FFF8 + ep || inst2 !== 32'hFFFF_FFF8 + ep) begin errors++; $display("FAIL wrap_pc k=%0d got %h exp %h", k, pc2, 32'hFFFF_FFF8 + ep); end
            end
        end
    endtask

    task automatic test_gnt_delay();
        logic        waiting;
        logic [31:0] last_addr;
        int          nreq = 0, nval = 0;
        do_reset();
        gnt_delay = 3;
        #1;
        waiting = imem_req && !imem_gnt; last_addr = imem_addr;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (imem_req && waiting) begin
                checks++; if (imem_addr !== last_addr) begin errors++; $display("FAIL gd_addr_hold k=%0d got %h exp %h", k, imem_addr, last_addr); end
            end
            waiting = imem_req && !imem_gnt; last_addr = imem_addr;
            if (imem_req && imem_gnt) begin
                checks++; if (imem_addr !== 32'(nreq * 4)) begin errors++; $display("FAIL gd_req k=%0d got %h exp %h", k, imem_addr, nreq * 4); end
                nreq++;
            end
            if (inst_valid) begin
                checks++; if (pc !== 32'(nval * 4) || inst !== pc) begin errors++; $display("FAIL gd_inst k=%0d got %h/%h exp %h", k, pc, inst, nval * 4); end
                nval++;
            end
        end
        checks++; if (nreq != 5 || nval != 4) begin errors++; $display("FAIL gd_counts got %0d/%0d exp 5/4", nreq, nval); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        rsp_lat = 2;
        @(negedge clk);  // k1: WAIT, response not back yet
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bw_req got %b exp 0", imem_req); end
        branch_taken = 1'b1; jump_addr = 32'h100;
        @(negedge clk);  // k2
        branch_taken = 1'b0;
        checks++; if (inst_valid !== 1'b0 || inst !== NOP_INST) begin errors++; $display("FAIL bw_bubble got %b/%h exp 0/%h", inst_valid, inst, NOP_INST); end
        @(negedge clk);  // k3: stale response present
        rsp_lat = 0;
        @(negedge clk);  // k4
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bw_drop got %b exp 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL bw_target got %b/%h exp 1/100", imem_req, imem_addr); end
        @(negedge clk); @(negedge clk);  // k6
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h100 || inst !== 32'h100) begin errors++; $display("FAIL bw_inst got %b/%h exp 1/100", inst_valid, pc); end
        @(negedge clk);  // k7: response for 0x104 arrives with a redirect
        branch_taken = 1'b1; jump_addr = 32'h300;
        @(negedge clk);  // k8
        branch_taken = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL bw_same got %b/%b/%h exp 0/1/300", inst_valid, imem_req, imem_addr); end
        @(negedge clk); @(negedge clk);  // k10
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h300) begin errors++; $display("FAIL bw_same_inst got %b/%h exp 1/300", inst_valid, pc); end
    endtask

    task automatic test_branch_req();
        do_reset();
        gnt_delay = 2; branch_taken = 1'b1; jump_addr = 32'h40;
        @(negedge clk);  // k1
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL br_hold1 got %b/%h exp 1/0", imem_req, imem_addr); end
        @(negedge clk);  // k2: granted now
        checks++; if (imem_gnt !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL br_hold2 got %b/%h exp 1/0", imem_gnt, imem_addr); end
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL br_target got %b/%h exp 1/40", imem_req, imem_addr); end
            end
            if (k < 8) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL br_killed k=%0d got %b exp 0", k, inst_valid); end
            end else begin
                checks++; if (inst_valid !== 1'b1 || pc !== 32'h40 || inst !== 32'h40) begin errors++; $display("FAIL br_inst got %b/%h exp 1/40", inst_valid, pc); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk); @(negedge clk);  // k2: pc 0 valid
        stall = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL st_hold k=%0d got %b/%h exp 1/0", k, inst_valid, pc); end
            if (k >= 4) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req k=%0d got %b exp 0", k, imem_req); end
            end
        end
        stall = 1'b0;
        @(negedge clk);  // k7
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h4 || inst !== 32'h4) begin errors++; $display("FAIL st_skid got %b/%h exp 1/4", inst_valid, pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL st_resume got %b/%h exp 1/8", imem_req, imem_addr); end
        @(negedge clk);  // k8
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL st_dup got %b exp 0", inst_valid); end
        @(negedge clk);  // k9
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL st_next got %b/%h exp 1/8", inst_valid, pc); end
    endtask

    task automatic test_clk_en();
        do_reset();
        @(negedge clk); @(negedge clk);  // k2
        clk_en = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4) begin errors++; $display("FAIL ce_freeze got %b/%h/%h exp 1/0/4", inst_valid, pc, imem_addr); end
        clk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL ce_resume got %b/%h exp 1/4", inst_valid, pc); end
    endtask

`ifdef IF_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset();
        checks++; if (if_misalign !== 1'b0) begin errors++; $display("FAIL ma_rst got %b exp 0", if_misalign); end
        branch_taken = 1'b1; jump_addr = 32'h102;
        @(negedge clk);  // k1
        branch_taken = 1'b0;
        checks++; if (if_misalign !== 1'b1) begin errors++; $display("FAIL ma_flag got %b exp 1", if_misalign); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL ma_block k=%0d got %b/%b exp 0/0", k, imem_req, inst_valid); end
        end
        branch_taken = 1'b1; jump_addr = 32'h200;
        @(negedge clk);  // k6
        branch_taken = 1'b0;
        checks++; if (if_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL ma_clear got %b/%b/%h exp 0/1/200", if_misalign, imem_req, imem_addr); end
        @(negedge clk); @(negedge clk);  // k8
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h200) begin errors++; $display("FAIL ma_inst got %b/%h exp 1/200", inst_valid, pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_branch_wait();
        test_branch_req();
        test_stall();
        test_clk_en();
`ifdef IF_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
